// File: rtl/time_set_controller.sv
// time_set_controller: 24-hour time-setting mode sequencer.
// Captures the live time, lets the user edit hours then minutes with
// inc/dec, and issues a one-cycle load on confirm. Cancel or an
// inactivity timeout (counted in tick_1hz pulses) abandons the edit.
// Every output is registered from the next-state logic, so a pulse
// sampled at edge N shows up on the outputs right after edge N.
module time_set_controller #(
  parameter int HOUR_MAX      = 23,
  parameter int MIN_MAX       = 59,
  parameter int TIMEOUT_TICKS = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_btn,
  input  logic       inc_btn,
  input  logic       dec_btn,
  input  logic       cancel_btn,
  input  logic       tick_1hz,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  output logic [4:0] edit_hours,
  output logic [5:0] edit_minutes,
  output logic       blink_hours,
  output logic       blink_minutes,
  output logic       setting,
  output logic       load
);

  localparam int CW = $clog2(TIMEOUT_TICKS + 1);

  typedef enum logic [1:0] {IDLE, EDIT_H, EDIT_M, COMMIT} state_t;

  // Button pulses bundled so the edit-state decode reads as one request.
  typedef struct packed {
    logic set;
    logic inc;
    logic dec;
    logic cancel;
  } btn_t;

  btn_t          btn;
  state_t        state, state_nxt;
  logic [4:0]    hours_nxt;
  logic [5:0]    mins_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_tick;
  logic          any_btn, step_up, step_dn;
  logic [4:0]    hours_up, hours_dn, hours_cap;
  logic [5:0]    mins_up, mins_dn, mins_cap;

  assign btn      = '{set: set_btn, inc: inc_btn, dec: dec_btn, cancel: cancel_btn};
  assign any_btn  = |btn;
  // inc and dec together cancel out; they still count as activity.
  assign step_up  = btn.inc & ~btn.dec;
  assign step_dn  = btn.dec & ~btn.inc;
  assign cnt_tick = cnt + CW'(1);

  // Wrapped neighbours of the current field values.
  assign hours_up = (edit_hours == 5'(HOUR_MAX)) ? '0 : edit_hours + 5'd1;
  assign hours_dn = (edit_hours == '0) ? 5'(HOUR_MAX) : edit_hours - 5'd1;
  assign mins_up  = (edit_minutes == 6'(MIN_MAX)) ? '0 : edit_minutes + 6'd1;
  assign mins_dn  = (edit_minutes == '0) ? 6'(MIN_MAX) : edit_minutes - 6'd1;

  // Out-of-range live values are not editable starting points; start at 0.
  assign hours_cap = (cur_hours > 5'(HOUR_MAX)) ? '0 : cur_hours;
  assign mins_cap  = (cur_minutes > 6'(MIN_MAX)) ? '0 : cur_minutes;

  // Next state, edit values and inactivity counter.
  always_comb begin
    state_nxt = state;
    hours_nxt = edit_hours;
    mins_nxt  = edit_minutes;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (btn.set) begin
          state_nxt = EDIT_H;
          hours_nxt = hours_cap;
          mins_nxt  = mins_cap;
        end
      end
      EDIT_H, EDIT_M: begin
        // Any button restarts the inactivity window, even on a tick cycle.
        if (any_btn)       cnt_nxt = '0;
        else if (tick_1hz) cnt_nxt = cnt_tick;

        if (btn.cancel) begin
          state_nxt = IDLE;
        end else if (btn.set) begin
          state_nxt = (state == EDIT_H) ? EDIT_M : COMMIT;
        end else if (step_up) begin
          if (state == EDIT_H) hours_nxt = hours_up;
          else                 mins_nxt  = mins_up;
        end else if (step_dn) begin
          if (state == EDIT_H) hours_nxt = hours_dn;
          else                 mins_nxt  = mins_dn;
        end else if (!any_btn && tick_1hz && cnt_tick == CW'(TIMEOUT_TICKS)) begin
          state_nxt = IDLE;
        end
      end
      COMMIT: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, edit registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      edit_hours    <= '0;
      edit_minutes  <= '0;
      cnt           <= '0;
      blink_hours   <= 1'b0;
      blink_minutes <= 1'b0;
      setting       <= 1'b0;
      load          <= 1'b0;
    end else begin
      state         <= state_nxt;
      edit_hours    <= hours_nxt;
      edit_minutes  <= mins_nxt;
      cnt           <= cnt_nxt;
      blink_hours   <= (state_nxt == EDIT_H);
      blink_minutes <= (state_nxt == EDIT_M);
      setting       <= (state_nxt != IDLE);
      load          <= (state_nxt == COMMIT);
    end
  end

endmodule

// File: tb/tb_time_set_controller.sv
// Bench for time_set_controller: directed steps followed by random pulses,
// all checked against a mode/field model built from modulo arithmetic.
module tb_time_set_controller;

  localparam int HM = 23;
  localparam int MM = 59;
  localparam int TO = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       set_btn = 1'b0, inc_btn = 1'b0, dec_btn = 1'b0;
  logic       cancel_btn = 1'b0, tick_1hz = 1'b0;
  logic [4:0] cur_hours = '0;
  logic [5:0] cur_minutes = '0;
  logic [4:0] edit_hours;
  logic [5:0] edit_minutes;
  logic       blink_hours, blink_minutes, setting, load;

  int total = 0;
  int bad = 0;

  // Model: mode 0=idle, 1=hours, 2=minutes, 3=committing.
  int m_mode, m_h, m_m, m_cnt;

  time_set_controller #(.HOUR_MAX(HM), .MIN_MAX(MM), .TIMEOUT_TICKS(TO)) dut (
    .clk(clk), .rst_n(rst_n), .set_btn(set_btn), .inc_btn(inc_btn),
    .dec_btn(dec_btn), .cancel_btn(cancel_btn), .tick_1hz(tick_1hz),
    .cur_hours(cur_hours), .cur_minutes(cur_minutes),
    .edit_hours(edit_hours), .edit_minutes(edit_minutes),
    .blink_hours(blink_hours), .blink_minutes(blink_minutes),
    .setting(setting), .load(load)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    m_mode = 0; m_h = 0; m_m = 0; m_cnt = 0;
  endtask

  task automatic check_all();
    chk("setting",  32'(setting),       32'(m_mode != 0));
    chk("blink_h",  32'(blink_hours),   32'(m_mode == 1));
    chk("blink_m",  32'(blink_minutes), 32'(m_mode == 2));
    chk("load",     32'(load),          32'(m_mode == 3));
    chk("edit_h",   32'(edit_hours),    m_h);
    chk("edit_m",   32'(edit_minutes),  m_m);
  endtask

  task automatic model_step(input logic s, i, d, c, t,
                            input logic [4:0] ch, input logic [5:0] cm);
    case (m_mode)
      0: if (s) begin
        m_mode = 1; m_cnt = 0;
        m_h = (ch > HM) ? 0 : ch;
        m_m = (cm > MM) ? 0 : cm;
      end
      1, 2: begin
        if (s || i || d || c) m_cnt = 0;
        else if (t)           m_cnt++;
        if (c)                m_mode = 0;
        else if (s)           m_mode++;
        else if (i && !d) begin
          if (m_mode == 1) m_h = (m_h + 1) % (HM + 1);
          else             m_m = (m_m + 1) % (MM + 1);
        end else if (d && !i) begin
          if (m_mode == 1) m_h = (m_h + HM) % (HM + 1);
          else             m_m = (m_m + MM) % (MM + 1);
        end else if (m_cnt == TO) m_mode = 0;
      end
      default: m_mode = 0;
    endcase
  endtask

  task automatic step(input logic s, i, d, c, t,
                      input logic [4:0] ch, input logic [5:0] cm);
    @(negedge clk);
    set_btn = s; inc_btn = i; dec_btn = d; cancel_btn = c; tick_1hz = t;
    cur_hours = ch; cur_minutes = cm;
    model_step(s, i, d, c, t, ch, cm);
    @(posedge clk);
    #1 check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, cur_hours, cur_minutes);
  endtask

  initial begin
    mreset();
    #3 check_all();                       // in reset
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Enter at 13:45, hours +2, minutes -3, confirm.
    step(1, 0, 0, 0, 0, 5'd13, 6'd45);
    chk("enter_h", 32'(edit_hours), 13);
    chk("enter_m", 32'(edit_minutes), 45);
    chk("enter_blink_h", 32'(blink_hours), 1);
    step(0, 1, 0, 0, 0, 5'd13, 6'd45);
    step(0, 1, 0, 0, 0, 5'd13, 6'd45);
    step(1, 0, 0, 0, 0, 5'd13, 6'd45);
    step(0, 0, 1, 0, 0, 5'd13, 6'd45);
    step(0, 0, 1, 0, 0, 5'd13, 6'd45);
    step(0, 0, 1, 0, 0, 5'd13, 6'd45);
    step(1, 0, 0, 0, 0, 5'd13, 6'd45);
    chk("commit_load", 32'(load), 1);
    chk("commit_h", 32'(edit_hours), 15);
    chk("commit_m", 32'(edit_minutes), 42);
    idle(1);
    chk("after_commit_setting", 32'(setting), 0);
    chk("after_commit_load", 32'(load), 0);

    // Wrap at both ends of both fields, inc+dec together, cancel.
    step(1, 0, 0, 0, 0, 5'd23, 6'd59);
    step(0, 1, 0, 0, 0, 5'd23, 6'd59);
    chk("h_wrap_up", 32'(edit_hours), 0);
    step(0, 0, 1, 0, 0, 5'd23, 6'd59);
    chk("h_wrap_dn", 32'(edit_hours), 23);
    step(1, 0, 0, 0, 0, 5'd23, 6'd59);
    step(0, 1, 0, 0, 0, 5'd23, 6'd59);
    chk("m_wrap_up", 32'(edit_minutes), 0);
    step(0, 0, 1, 0, 0, 5'd23, 6'd59);
    chk("m_wrap_dn", 32'(edit_minutes), 59);
    chk("m_blink", 32'(blink_minutes), 1);
    step(0, 1, 1, 0, 0, 5'd23, 6'd59);
    chk("incdec_same", 32'(edit_minutes), 59);
    step(0, 0, 0, 1, 0, 5'd23, 6'd59);
    chk("cancel_setting", 32'(setting), 0);
    idle(2);

    // set+inc together in hours advances without touching hours.
    step(1, 0, 0, 0, 0, 5'd10, 6'd20);
    step(1, 1, 0, 0, 0, 5'd10, 6'd20);
    chk("setinc_blink_m", 32'(blink_minutes), 1);
    chk("setinc_h", 32'(edit_hours), 10);
    step(0, 0, 0, 1, 0, 5'd10, 6'd20);

    // Timeout: three quiet ticks abandon the edit.
    step(1, 0, 0, 0, 0, 5'd5, 6'd6);
    step(0, 0, 0, 0, 1, 5'd5, 6'd6);
    step(0, 0, 0, 0, 1, 5'd5, 6'd6);
    chk("to_not_yet", 32'(setting), 1);
    step(0, 0, 0, 0, 1, 5'd5, 6'd6);
    chk("to_expired", 32'(setting), 0);
    // Button on tick 2 restarts the window.
    step(1, 0, 0, 0, 0, 5'd5, 6'd6);
    step(0, 0, 0, 0, 1, 5'd5, 6'd6);
    step(0, 1, 0, 0, 1, 5'd5, 6'd6);
    step(0, 0, 0, 0, 1, 5'd5, 6'd6);
    step(0, 0, 0, 0, 1, 5'd5, 6'd6);
    chk("to_restarted", 32'(setting), 1);
    step(0, 0, 0, 0, 1, 5'd5, 6'd6);
    chk("to_after_restart", 32'(setting), 0);

    // Out-of-range capture.
    step(1, 0, 0, 0, 0, 5'd28, 6'd61);
    chk("clamp_h", 32'(edit_hours), 0);
    chk("clamp_m", 32'(edit_minutes), 0);
    step(0, 0, 0, 1, 0, 5'd28, 6'd61);

    // Reset while committing.
    step(1, 0, 0, 0, 0, 5'd7, 6'd8);
    step(1, 0, 0, 0, 0, 5'd7, 6'd8);
    step(1, 0, 0, 0, 0, 5'd7, 6'd8);
    chk("pre_reset_load", 32'(load), 1);
    #2 rst_n = 1'b0;
    mreset();
    #1 check_all();
    @(negedge clk);
    set_btn = 0; inc_btn = 0; dec_btn = 0; cancel_btn = 0; tick_1hz = 0;
    rst_n = 1'b1;
    idle(1);

    // Random pulses against the model.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(7) == 0), ($urandom_range(3) == 0),
           ($urandom_range(3) == 0), ($urandom_range(19) == 0),
           ($urandom_range(2) == 0),
           5'($urandom_range(31)), 6'($urandom_range(63)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
